// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: default width, legal range
// and the registered FSM state encoding.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int MIN_WIDTH     = 2;
    localparam int MAX_WIDTH     = 32;

    localparam logic [1:0] ENC_IDLE = 2'd0;
    localparam logic [1:0] ENC_RUN  = 2'd1;
    localparam logic [1:0] ENC_DONE = 2'd2;

    typedef enum logic [1:0] {
        SHIFT_IDLE = ENC_IDLE,
        SHIFT_RUN  = ENC_RUN,
        SHIFT_DONE = ENC_DONE
    } shift_state_t;

    // Width of the bit counter that walks a WIDTH-bit operand.
    function automatic int count_bits(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/serial_adder_full_add_cell.sv
// One-bit full adder used as the single arithmetic cell of the serial adder.
module full_add_cell (
    input  logic a,
    input  logic b,
    input  logic carry_in,
    output logic sum,
    output logic carry
);

    logic half_sum;

    assign half_sum = a ^ b;
    assign sum      = half_sum ^ carry_in;
    assign carry    = (a & b) | (carry_in & half_sum);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: adds two WIDTH-bit operands plus a carry one bit per
// clock through a single full-add cell, LSB first.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output shift_state_t     state
);

    // Handshake: start is sampled only in IDLE; the accepting edge captures
    // a, b and carry_in. busy is high for the WIDTH RUN cycles, done pulses
    // for one cycle afterwards, and sum/carry_out then hold until the next
    // accepted start. Requests outside IDLE are dropped, not queued.

    localparam int CW = count_bits(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             carry_reg;
    logic [CW-1:0]    bit_cnt;
    logic             cell_sum;
    logic             cell_carry;

    full_add_cell u_cell (
        .a        (a_reg[0]),
        .b        (b_reg[0]),
        .carry_in (carry_reg),
        .sum      (cell_sum),
        .carry    (cell_carry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SHIFT_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            bit_cnt   <= '0;
        end else begin
            case (state)
                SHIFT_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        carry_reg <= carry_in;
                        bit_cnt   <= '0;
                        busy      <= 1'b1;
                        state     <= SHIFT_RUN;
                    end
                end
                SHIFT_RUN: begin
                    // Sum bits enter at the MSB so after WIDTH shifts bit 0
                    // of the result has reached sum_reg[0].
                    a_reg     <= a_reg >> 1;
                    b_reg     <= b_reg >> 1;
                    sum_reg   <= {cell_sum, sum_reg[WIDTH-1:1]};
                    carry_reg <= cell_carry;
                    bit_cnt   <= bit_cnt + CW'(1);
                    if (bit_cnt == LAST_BIT) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= SHIFT_DONE;
                    end
                end
                SHIFT_DONE: begin
                    done  <= 1'b0;
                    state <= SHIFT_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= SHIFT_IDLE;
                end
            endcase
        end
    end

    // The carry flop ends the last RUN edge holding the final carry.
    assign sum       = sum_reg;
    assign carry_out = carry_reg;

endmodule
